// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall sequencer for the five-stage pipeline: load-use stalls, EX branch flushes, data-memory freezes.
// Optional HAZARD_PERF_CNT_EN adds saturating stall-cycle and flush counters.
module hazard_stall_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       ifid_uses_rt,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rt,
    input  logic       ex_branch_taken,
    input  logic       mem_busy,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_write,
    output logic       idex_bubble,
    output logic       exmem_write,
    output logic [1:0] state_out
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        ILLEGAL    = 2'd3
    } state_t;

    state_t     state, state_nxt;
    state_t     saved, saved_nxt;
    state_t     eff;
    logic [2:0] cnt, cnt_nxt;
    logic       lu;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            saved <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            saved <= saved_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign lu = idex_mem_read && (idex_rt != 5'd0) &&
                ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    always_comb begin
        state_nxt   = state;
        saved_nxt   = saved;
        cnt_nxt     = cnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_bubble = 1'b0;
        exmem_write = 1'b1;
        // Releasing from MEM_WAIT behaves exactly like the state the freeze interrupted.
        eff = (state == MEM_WAIT) ? saved : state;

        if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            state_nxt   = MEM_WAIT;
            if (state == LOAD_STALL)
                saved_nxt = LOAD_STALL;
            else if (state != MEM_WAIT)
                saved_nxt = RUN;
        end else begin
            case (eff)
                RUN, LOAD_STALL: begin
                    if (ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        state_nxt   = RUN;
                        cnt_nxt     = '0;
                    end else if (eff == LOAD_STALL || lu) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        if (eff == LOAD_STALL) begin
                            if (cnt <= 3'd1) begin
                                state_nxt = RUN;
                                cnt_nxt   = '0;
                            end else begin
                                state_nxt = LOAD_STALL;
                                cnt_nxt   = cnt - 3'd1;
                            end
                        end else if (LOAD_STALL_CYCLES <= 1) begin
                            state_nxt = RUN;
                        end else begin
                            state_nxt = LOAD_STALL;
                            cnt_nxt   = 3'(LOAD_STALL_CYCLES - 1);
                        end
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end

        if (!reset_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_write  = 1'b1;
            idex_bubble = 1'b1;
            exmem_write = 1'b0;
        end
    end

    assign state_out = state;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (!pc_write && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (ifid_flush && (perf_flush_count != '1))
                perf_flush_count <= perf_flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: two instances (stall length 1 and 3) share directed stimulus.
// Expected word per cycle: {state_out, pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write}.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
    logic       ifid_uses_rt = 1'b0, idex_mem_read = 1'b0;
    logic       ex_branch_taken = 1'b0, mem_busy = 1'b0;

    logic       pcw1, ifw1, iff1, idw1, idb1, exw1;
    logic       pcw3, ifw3, iff3, idw3, idb3, exw3;
    logic [1:0] st1, st3;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] psc1, pfc1, psc3, pfc3;
`endif

    always #5 clk = ~clk;

    hazard_stall_ctrl dut1 (
        .clk(clk), .reset_n(reset_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(pcw1), .ifid_write(ifw1), .ifid_flush(iff1), .idex_write(idw1),
        .idex_bubble(idb1), .exmem_write(exw1), .state_out(st1)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cycles(psc1), .perf_flush_count(pfc1)
`endif
    );

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(pcw3), .ifid_write(ifw3), .ifid_flush(iff3), .idex_write(idw3),
        .idex_bubble(idb3), .exmem_write(exw3), .state_out(st3)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cycles(psc3), .perf_flush_count(pfc3)
`endif
    );

    localparam logic [7:0] RST   = 8'h0E;
    localparam logic [7:0] NORM  = 8'h35;
    localparam logic [7:0] NORMW = 8'hB5;
    localparam logic [7:0] STR   = 8'h07;
    localparam logic [7:0] STL   = 8'h47;
    localparam logic [7:0] STW   = 8'h87;
    localparam logic [7:0] FLR   = 8'h3F;
    localparam logic [7:0] FLL   = 8'h7F;
    localparam logic [7:0] FLW   = 8'hBF;
    localparam logic [7:0] BSR   = 8'h00;
    localparam logic [7:0] BSL   = 8'h40;
    localparam logic [7:0] BSW   = 8'h80;

    typedef struct {
        int unsigned idx;
        logic [7:0]  e1;
        logic [7:0]  e3;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n_step = 0;

    // inputs: rst_n, mem_read, idex_rt, rs, rt, uses_rt, branch, busy
    task automatic step(input logic r, input logic mr, input logic [4:0] xrt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic br, input logic busy,
                        input logic [7:0] e1, input logic [7:0] e3);
        exp_t e;
        reset_n = r; idex_mem_read = mr; idex_rt = xrt; ifid_rs = rs;
        ifid_rt = rt; ifid_uses_rt = urt; ex_branch_taken = br; mem_busy = busy;
        n_step++;
        e.idx = n_step; e.e1 = e1; e.e3 = e3;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            logic [7:0] a1, a3;
            e = sb.pop_front();
            a1 = {st1, pcw1, ifw1, iff1, idw1, idb1, exw1};
            a3 = {st3, pcw3, ifw3, iff3, idw3, idb3, exw3};
            n_cmp++;
            if (a1 !== e.e1) begin
                n_bad++;
                $display("FAIL step%0d_len1: got %h expected %h", e.idx, a1, e.e1);
            end
            n_cmp++;
            if (a3 !== e.e3) begin
                n_bad++;
                $display("FAIL step%0d_len3: got %h expected %h", e.idx, a3, e.e3);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // reset held three cycles
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, RST, RST);
        step(1, 0, 0, 0, 0, 0, 0, 0, NORM, NORM);
        // load-use via rs
        step(1, 1, 5, 5, 0, 0, 0, 0, STR, STR);
        step(1, 0, 0, 0, 0, 0, 0, 0, NORM, STL);
        step(1, 0, 0, 0, 0, 0, 0, 0, NORM, STL);
        step(1, 0, 0, 0, 0, 0, 0, 0, NORM, NORM);
        // load-use via rt with uses_rt
        step(1, 1, 5, 3, 5, 1, 0, 0, STR, STR);
        step(1, 0, 0, 0, 0, 0, 0, 0, NORM, STL);
        step(1, 0, 0, 0, 0, 0, 0, 0, NORM, STL);
        step(1, 0, 0, 0, 0, 0, 0, 0, NORM, NORM);
        // rt match ignored without uses_rt; register zero never stalls
        step(1, 1, 5, 3, 5, 0, 0, 0, NORM, NORM);
        step(1, 1, 0, 0, 0, 1, 0, 0, NORM, NORM);
        // branch in second stall cycle
        step(1, 1, 5, 5, 0, 0, 0, 0, STR, STR);
        step(1, 0, 0, 0, 0, 0, 1, 0, FLR, FLL);
        step(1, 0, 0, 0, 0, 0, 0, 0, NORM, NORM);
        // branch outranks load-use
        step(1, 1, 5, 5, 0, 0, 1, 0, FLR, FLR);
        // mem_busy for 4 cycles entering from LOAD_STALL cnt=2
        step(1, 1, 5, 5, 0, 0, 0, 0, STR, STR);
        step(1, 0, 0, 0, 0, 0, 0, 1, BSR, BSL);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 1, BSW, BSW);
        step(1, 0, 0, 0, 0, 0, 0, 0, NORMW, STW);
        step(1, 0, 0, 0, 0, 0, 0, 0, NORM, STL);
        step(1, 0, 0, 0, 0, 0, 0, 0, NORM, NORM);
        // load-use held through a freeze acts on the release cycle
        step(1, 1, 5, 5, 0, 0, 0, 1, BSR, BSR);
        step(1, 1, 5, 5, 0, 0, 0, 0, STW, STW);
        step(1, 0, 0, 0, 0, 0, 0, 0, NORM, STL);
        step(1, 0, 0, 0, 0, 0, 0, 0, NORM, STL);
        step(1, 0, 0, 0, 0, 0, 0, 0, NORM, NORM);
        // branch held through a freeze
        step(1, 0, 0, 0, 0, 0, 1, 1, BSR, BSR);
        step(1, 0, 0, 0, 0, 0, 1, 0, FLW, FLW);
        step(1, 0, 0, 0, 0, 0, 0, 0, NORM, NORM);
        // asynchronous reset overrides a live hazard
        step(0, 1, 5, 5, 0, 0, 1, 0, RST, RST);
        step(1, 0, 0, 0, 0, 0, 0, 0, NORM, NORM);

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Hazard and stall sequencer for the five-stage pipeline. It drives the write-enable, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers. It handles three cases: load-use hazards (with configurable stall length), taken-branch flushes resolved in EX, and data-memory wait states. It sits beside the ID stage and watches the IF/ID and ID/EX register contents.

Parameters:
LOAD_STALL_CYCLES, 1, total bubble cycles inserted per load-use hazard; legal range 1..7.

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
ifid_rs  in  5  rs field of instruction in IF/ID
ifid_rt  in  5  rt field of instruction in IF/ID
ifid_uses_rt  in  1  IF/ID instruction reads rt as a source
idex_mem_read  in  1  MemRead of instruction in ID/EX
idex_rt  in  5  destination rt of instruction in ID/EX
ex_branch_taken  in  1  branch in EX resolved taken this cycle
mem_busy  in  1  data memory not ready; pipeline must freeze
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads a NOP
idex_write  out  1  ID/EX load enable
idex_bubble  out  1  ID/EX loads zeroed control signals
exmem_write  out  1  EX/MEM (and MEM/WB) load enable
state_out  out  2  current state: 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT

Behaviour:
- Reset is asynchronous and active-low on reset_n; the clock is clk.
- While reset_n=0:
  - state=RUN, stall counter cnt=0, saved state=RUN.
  - Outputs forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_write=1, idex_bubble=1, exmem_write=0.
- Outputs are combinational from the registered state plus the current inputs. The state register, cnt and the saved state update on posedge clk.
- Load-use hazard lu = idex_mem_read & (idex_rt!=0) & ((idex_rt==ifid_rs) | (ifid_uses_rt & idex_rt==ifid_rt)).
- Evaluation priority, highest first: mem_busy, ex_branch_taken, load-use/stall.
- mem_busy=1 (any state), same cycle:
  - All write enables 0 (pc_write, ifid_write, idex_write, exmem_write).
  - ifid_flush=0, idex_bubble=0.
  - Next state=MEM_WAIT.
  - The saved state latches the current state, except when already in MEM_WAIT. cnt is held.
- MEM_WAIT with mem_busy=0: outputs and the next state are computed exactly as if in the saved state with cnt unchanged. Consequently, a branch or load-use held during the freeze takes effect on the release cycle.
- RUN, no hazard: pc_write=1, ifid_write=1, idex_write=1, exmem_write=1, ifid_flush=0, idex_bubble=0.
- ex_branch_taken=1 (RUN or LOAD_STALL):
  - pc_write=1, ifid_flush=1, idex_bubble=1, idex_write=1, exmem_write=1.
  - Next state=RUN, cnt=0. Any pending load stall is aborted.
- RUN with lu=1:
  - pc_write=0, ifid_write=0, idex_bubble=1, idex_write=1, exmem_write=1.
  - If LOAD_STALL_CYCLES=1, stay in RUN.
  - Otherwise go to LOAD_STALL with cnt=LOAD_STALL_CYCLES-1.
- LOAD_STALL:
  - Same stall outputs as RUN with lu=1, regardless of lu.
  - If cnt==1, next state=RUN; otherwise cnt decrements.
- Total bubbles per hazard = LOAD_STALL_CYCLES. Hazard detection is re-evaluated in RUN afterwards, so a persisting match stalls again.
- idex_rt==0 never causes a stall.
- Encoding 3 on state_out is illegal. An implementation reaching it returns to RUN on the next clock.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs perf_stall_cycles[31:0] and perf_flush_count[31:0], registered and reset to 0 by reset_n.
  - perf_stall_cycles increments each cycle that pc_write=0 with reset_n=1.
  - perf_flush_count increments each cycle that ifid_flush=1 with reset_n=1.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 three cycles, then release with no hazards -> during reset pc_write=0, idex_bubble=1, ifid_flush=1; first cycle after release all write enables 1, state_out=0.
- Load-use, default parameter: idex_mem_read=1, idex_rt=5, ifid_rs=5 for one cycle -> exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1, then normal operation; state_out stays 0.
- Load-use, LOAD_STALL_CYCLES=3, ifid_rt=5 with ifid_uses_rt=1 -> three consecutive stall cycles, state_out sequence 0,1,1,0.
- Branch during stall: LOAD_STALL_CYCLES=3, assert ex_branch_taken in the 2nd stall cycle -> that cycle ifid_flush=1, idex_bubble=1, pc_write=1; next cycle state_out=0.
- Memory wait: in LOAD_STALL with cnt=2, assert mem_busy for 4 cycles -> all write enables 0 for 4 cycles, state_out=2 for cycles 2-4, then 2 more stall cycles before RUN.
- Register zero: idex_mem_read=1, idex_rt=0, ifid_rs=0 -> no stall; pc_write stays 1. With HAZARD_PERF_CNT_EN, perf_stall_cycles stays 0.
